mobo_mem_responder: RTL and testbench

MOBO_MEM_RESPONDER -- requirements
Module: mobo_mem_responder

---
 rtl/mobo_mem_responder_pkg.sv | 29 ++
 rtl/mobo_mem_responder_if.sv | 23 ++
 rtl/mobo_mem_responder_ram.sv | 31 +++
 rtl/mobo_mem_responder.sv | 120 ++++++++++++
 tb/tb_mobo_mem_responder.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mobo_mem_responder_pkg.sv
// Shared definitions for the CPU memory bus: control/status bit positions,
// responder state encoding and small sizing helpers. The CPU side imports the
// same package so both ends agree on bit placement.
package mobo_mem_responder_pkg;

  // Command word bits driven by the CPU
  localparam int REQ_BIT  = 0;
  localparam int WE_BIT   = 1;

  // Status word bits driven by the responder
  localparam int ACK_BIT  = 0;
  localparam int BUSY_BIT = 1;
  localparam int ERR_BIT  = 2;

  // Wait counter covers 0..15 extra cycles
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Address bits needed to index a memory of the given depth
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mobo_mem_responder_if.sv
// CPU read/write bus: command, address and write data from the CPU,
// status and read data back from the memory responder.
interface mobo_mem_responder_if #(
  parameter int word_width = 32
);

  logic [word_width-1:0] mobo_ctrl;
  logic [word_width-1:0] mobo_addr;
  logic [word_width-1:0] mobo_wdata;
  logic [word_width-1:0] mobo_stat;
  logic [word_width-1:0] mobo_rdata;

  modport master (
    output mobo_ctrl, mobo_addr, mobo_wdata,
    input  mobo_stat, mobo_rdata
  );

  modport slave (
    input  mobo_ctrl, mobo_addr, mobo_wdata,
    output mobo_stat, mobo_rdata
  );

endinterface

// File: rtl/mobo_mem_responder_ram.sv
// Single-port storage array: synchronous write, registered read. Contents
// and read register are deliberately not reset.
module mobo_ram
  import mobo_mem_responder_pkg::*;
#(
  parameter int word_width = 32,
  parameter int DEPTH      = 256,
  parameter int AW         = addr_bits(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [word_width-1:0] wdata,
  output logic [word_width-1:0] rdata
);

  logic [word_width-1:0] mem [DEPTH];

  // One access per enabled cycle: either store wdata or capture the addressed word
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mobo_mem_responder.sv
// Memory responder for the CPU bus. Runs the 4-phase REQ/ACK handshake,
// inserts WAIT_CYCLES of extra latency, range-checks the full address word
// and commits the access to the RAM on the cycle ACK is raised.
module mobo_mem_responder
  import mobo_mem_responder_pkg::*;
#(
  parameter int word_width  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mobo_mem_responder_if.slave  bus
);

  localparam int                    AW        = addr_bits(DEPTH);
  localparam logic [CNT_W-1:0]      WAIT_INIT = CNT_W'(WAIT_CYCLES);
  // One extra bit so a DEPTH equal to 2^word_width still compares correctly
  localparam logic [word_width:0]   DEPTH_LIM = (word_width+1)'(DEPTH);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [word_width-1:0] addr_q;
  logic [word_width-1:0] wdata_q;
  logic                  we_q;
  logic                  ack_q;
  logic                  err_q;

  logic                  req;
  logic                  in_range;
  logic                  commit;
  logic [word_width-1:0] ram_rdata;
  logic [word_width-1:0] stat_word;
  logic                  ctrl_unused;

  assign req         = bus.mobo_ctrl[REQ_BIT];
  assign ctrl_unused = ^bus.mobo_ctrl;

  // Compare the whole latched address so high bits never alias into the array
  assign in_range = ({1'b0, addr_q} < DEPTH_LIM);

  // The access happens on the edge that moves WAIT -> ACK; reset on that edge
  // cancels it so an uncommitted write never lands
  assign commit = !rst && (state == ST_WAIT) && req && (cnt == '0);

  mobo_ram #(
    .word_width (word_width),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .en    (commit && in_range),
    .we    (we_q),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Handshake FSM with wait counter, request latches and registered ACK/ERR
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= bus.mobo_addr;
            wdata_q <= bus.mobo_wdata;
            we_q    <= bus.mobo_ctrl[WE_BIT];
            cnt     <= WAIT_INIT;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!req) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            ack_q <= 1'b1;
            err_q <= !in_range;
            state <= ST_ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ACK: begin
          if (!req) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status word assembled from registered state; unused bits read as zero
  always_comb begin
    stat_word           = '0;
    stat_word[ACK_BIT]  = ack_q;
    stat_word[BUSY_BIT] = (state != ST_IDLE);
    stat_word[ERR_BIT]  = err_q;
  end

  assign bus.mobo_stat = stat_word;

  // RAM output only shows through during a successful read acknowledge, so
  // writes, errors and idle time all present zero
  assign bus.mobo_rdata = (ack_q && !we_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_mobo_mem_responder.sv
// Self-checking bench for mobo_mem_responder: randomized accesses against a
// behavioural memory model, with a scoreboard monitor comparing every ACK.
module tb_mobo_mem_responder;
  import mobo_mem_responder_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 256;
  localparam int WA    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mobo_mem_responder_if #(.word_width(W)) ifa ();
  mobo_mem_responder_if #(.word_width(W)) ifb ();

  mobo_mem_responder #(.word_width(W), .DEPTH(DEPTH), .WAIT_CYCLES(WA)) ua (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  mobo_mem_responder #(.word_width(W), .DEPTH(DEPTH), .WAIT_CYCLES(0)) ub (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] ref_mem [DEPTH];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rising ACK pops one expected response
  task automatic monitor();
    logic        prev = 1'b0;
    logic [31:0] held = '0;
    logic        a;
    exp_t        e;
    forever begin
      @(negedge clk);
      a = ifa.mobo_stat[ACK_BIT];
      if (a && !prev) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got stat %h want no ACK", ifa.mobo_stat);
        end else begin
          e = sbq.pop_front();
          chk("rdata", ifa.mobo_rdata, e.rdata);
          chk("err", 32'(ifa.mobo_stat[ERR_BIT]), 32'(e.err));
          chk("ack_latency", 32'(cyc), 32'(e.cyc));
          held = ifa.mobo_rdata;
        end
      end else if (a) begin
        chk("rdata_stable", ifa.mobo_rdata, held);
        chk("busy_in_ack", 32'(ifa.mobo_stat[BUSY_BIT]), 32'd1);
      end
      prev = a;
    end
  endtask

  // Scramble everything except REQ after the request has been latched
  task automatic scramble();
    ifa.mobo_addr  = $urandom;
    ifa.mobo_wdata = $urandom;
    ifa.mobo_ctrl  = $urandom | 32'h1;
  endtask

  // One bus transaction on instance A. abort_n > 0 drops REQ after that many
  // sampled-high edges (before ACK); hold = extra cycles REQ stays up after ACK.
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input int abort_n, input int hold);
    bit   oob;
    bit   got;
    exp_t e;
    oob = (a >= DEPTH);
    @(negedge clk);
    ifa.mobo_ctrl  = ($urandom & ~32'h3) | {30'b0, we, 1'b1};
    ifa.mobo_addr  = a;
    ifa.mobo_wdata = d;
    if (abort_n == 0) begin
      e.rdata = (we || oob) ? 32'h0 : ref_mem[a[7:0]];
      e.err   = oob;
      e.cyc   = cyc + 2 + WA;
      sbq.push_back(e);
      if (we && !oob) ref_mem[a[7:0]] = d;
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
        @(negedge clk);
        if (ifa.mobo_stat[ACK_BIT]) begin
          got = 1'b1;
        end else begin
          chk("busy_in_wait", 32'(ifa.mobo_stat[BUSY_BIT]), 32'd1);
          scramble();
        end
      end
      if (!got) begin
        total++;
        bad++;
        $display("FAIL ack_timeout: got no ACK for addr %h want ACK", a);
        if (sbq.size() > 0) sbq.delete(sbq.size() - 1);
      end
      repeat (hold) begin
        @(negedge clk);
        scramble();
      end
      ifa.mobo_ctrl = $urandom & ~32'h1;
      @(negedge clk);
      chk("stat_after_drop", ifa.mobo_stat, 32'h0);
      chk("rdata_after_drop", ifa.mobo_rdata, 32'h0);
    end else begin
      repeat (abort_n) @(negedge clk);
      ifa.mobo_ctrl = $urandom & ~32'h1;
      @(negedge clk);
      chk("stat_after_abort", ifa.mobo_stat, 32'h0);
    end
  endtask

  // Plain write on instance B (no wait cycles), bounded wait for ACK
  task automatic b_write(input logic [31:0] a, input logic [31:0] d);
    bit got;
    @(negedge clk);
    ifb.mobo_ctrl  = 32'h3;
    ifb.mobo_addr  = a;
    ifb.mobo_wdata = d;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (ifb.mobo_stat[ACK_BIT]) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL b_ack_timeout: got no ACK for addr %h want ACK", a);
    end
    ifb.mobo_ctrl = 32'h0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] bx;
    logic [31:0] by;
    ifa.mobo_ctrl = '0; ifa.mobo_addr = '0; ifa.mobo_wdata = '0;
    ifb.mobo_ctrl = '0; ifb.mobo_addr = '0; ifb.mobo_wdata = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_stat_a", ifa.mobo_stat, 32'h0);
    chk("reset_rdata_a", ifa.mobo_rdata, 32'h0);
    chk("reset_stat_b", ifb.mobo_stat, 32'h0);
    rst = 1'b0;

    // Give the model a known image for the low region
    for (int i = 0; i < 64; i++) access(1'b1, 32'(i), $urandom, 0, 0);

    // Write then read back, REQ held extra cycles during ACK
    access(1'b1, 32'h10, 32'hDEADBEEF, 0, 1);
    access(1'b0, 32'h10, 32'h0, 0, 2);

    // Out-of-range read and write, then confirm address 0 untouched
    access(1'b0, 32'h100, 32'h0, 0, 0);
    access(1'b1, 32'h100, 32'hCAFEF00D, 0, 0);
    access(1'b0, 32'h0, 32'h0, 0, 0);

    // Write aborted after one sampled cycle leaves 0x20 as it was
    access(1'b1, 32'h20, 32'h1234, 1, 0);
    access(1'b0, 32'h20, 32'h0, 0, 0);

    // Reset on the very edge that would commit a write to 0x30
    @(negedge clk);
    ifa.mobo_ctrl  = 32'h3;
    ifa.mobo_addr  = 32'h30;
    ifa.mobo_wdata = 32'h5555AAAA;
    repeat (3) @(negedge clk);
    chk("busy_before_reset", 32'(ifa.mobo_stat[BUSY_BIT]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("stat_after_reset", ifa.mobo_stat, 32'h0);
    chk("rdata_after_reset", ifa.mobo_rdata, 32'h0);
    rst = 1'b0;
    ifa.mobo_ctrl = 32'h0;
    @(negedge clk);
    access(1'b0, 32'h30, 32'h0, 0, 0);

    // Randomized mix of reads, writes, out-of-range and aborted accesses
    for (int i = 0; i < 80; i++) begin
      int          kind;
      logic [31:0] a;
      logic [31:0] oa;
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, 63));
      case ($urandom_range(0, 2))
        0:       oa = 32'h100 + a;
        1:       oa = 32'h0001_0000 + a;
        default: oa = 32'hFFFF_FF00 | a;
      endcase
      if (kind <= 3)      access(1'b0, a, 32'h0, 0, $urandom_range(0, 3));
      else if (kind <= 6) access(1'b1, a, $urandom, 0, $urandom_range(0, 3));
      else if (kind == 7) access(1'($urandom_range(0, 1)), oa, $urandom, 0, 0);
      else if (kind == 8) access(1'b1, a, $urandom, $urandom_range(1, 2), 0);
      else                access(1'b0, a, 32'h0, $urandom_range(1, 2), 0);
    end

    // Zero-wait instance: address changed right after latching
    bx = 32'hA5A5_0005;
    by = 32'h5A5A_0006;
    b_write(32'h5, bx);
    b_write(32'h6, by);
    @(negedge clk);
    ifb.mobo_ctrl = 32'h1;
    ifb.mobo_addr = 32'h5;
    @(negedge clk);
    chk("b_ack_not_early", 32'(ifb.mobo_stat[ACK_BIT]), 32'd0);
    ifb.mobo_addr = 32'h6;
    @(negedge clk);
    chk("b_ack_latency", 32'(ifb.mobo_stat[ACK_BIT]), 32'd1);
    chk("b_rdata_latched_addr", ifb.mobo_rdata, bx);
    chk("b_err", 32'(ifb.mobo_stat[ERR_BIT]), 32'd0);
    ifb.mobo_ctrl = 32'h0;
    @(negedge clk);
    chk("b_stat_after_drop", ifb.mobo_stat, 32'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
